candidate_metric_select: RTL and testbench

- Consumes the candidate-row stream from the set-A candidate generator, one candidate per cycle, with no backpressure.
- Scores each candidate as the sum of per-position, per-symbol costs from a loadable cost table.
- Tracks the minimum-metric candidate across a frame, which is the run of beats ending at the tvalid&tlast beat.
- Emits the winning row and its metric once per frame to the downstream update stage.

---
 rtl/cand_pkg.sv | 18 +
 rtl/cand_cost_lut.sv | 71 +++++++
 rtl/candidate_metric_select.sv | 155 +++++++++++++++
 tb/tb_candidate_metric_select.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cand_pkg.sv
// cand_pkg: width derivations and constants shared by the candidate generator and selector
package cand_pkg;

    localparam logic [63:0] MET_MAX = '1;

    function automatic int awidth(input int a);
        return $clog2(a) + 1;
    endfunction

    function automatic int jwidth(input int j);
        return $clog2(j) + 1;
    endfunction

    function automatic int metw(input int cw, input int j);
        return cw + $clog2(j) + 1;
    endfunction

endpackage

// File: rtl/cand_cost_lut.sv
// cand_cost_lut: cost table storage, guarded write port and registered per-position lookup (S1)
module cand_cost_lut
    import cand_pkg::*;
#(
    parameter int J = 14,
    parameter int A = 2,
    parameter int COST_W = 16,
    localparam int AW = awidth(A),
    localparam int JW = jwidth(J)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [JW-1:0]         i_wr_j,
    input  logic [AW-1:0]         i_wr_a,
    input  logic [COST_W-1:0]     i_wr_data,
    input  logic                  i_frozen,
    output logic                  o_wr_err,
    input  logic [J*AW-1:0]       i_row,
    output logic [J*COST_W-1:0]   o_cost,
    output logic                  o_illegal
);

    logic [COST_W-1:0]   r_cost [J][A];
    logic                w_wr_ok;
    logic [J*COST_W-1:0] w_cost;
    logic                w_illegal;

    assign w_wr_ok = i_wr_en && !i_frozen && (i_wr_j < JW'(J)) && (i_wr_a < AW'(A));

    // table write; anything dropped (frozen table or out-of-range index) is flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < J; j++)
                for (int a = 0; a < A; a++)
                    r_cost[j][a] <= '0;
            o_wr_err <= 1'b0;
        end else begin
            o_wr_err <= i_wr_en && !w_wr_ok;
            for (int j = 0; j < J; j++)
                for (int a = 0; a < A; a++)
                    if (w_wr_ok && i_wr_j == JW'(j) && i_wr_a == AW'(a))
                        r_cost[j][a] <= i_wr_data;
        end
    end

    // per-position lookup; an out-of-alphabet symbol contributes 0 and marks the row ineligible
    always_comb begin
        w_cost = '0;
        w_illegal = 1'b0;
        for (int j = 0; j < J; j++) begin
            if (i_row[j*AW +: AW] >= AW'(A))
                w_illegal = 1'b1;
            for (int a = 0; a < A; a++)
                if (i_row[j*AW +: AW] == AW'(a))
                    w_cost[j*COST_W +: COST_W] = r_cost[j][a];
        end
    end

    // S1 lookup register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cost <= '0;
            o_illegal <= 1'b0;
        end else begin
            o_cost <= w_cost;
            o_illegal <= w_illegal;
        end
    end

endmodule

// File: rtl/candidate_metric_select.sv
// candidate_metric_select: per-frame minimum-metric candidate selection; CAND_METRIC_INDEX_EN adds best_index/frame_cnt
module candidate_metric_select
    import cand_pkg::*;
#(
    parameter int J = 14,
    parameter int A = 2,
    parameter int COST_W = 16,
    localparam int AWIDTH = awidth(A),
    localparam int J_WIDTH = jwidth(J),
    localparam int MET_W = metw(COST_W, J)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cost_wr_en,
    input  logic [J_WIDTH-1:0]    cost_wr_j,
    input  logic [AWIDTH-1:0]     cost_wr_a,
    input  logic [COST_W-1:0]     cost_wr_data,
    output logic                  cost_wr_err,
    input  logic [J*AWIDTH-1:0]   candidate_row,
    input  logic                  candidate_row_tvalid,
    input  logic                  candidate_row_tlast,
    output logic [J*AWIDTH-1:0]   best_row,
    output logic [MET_W-1:0]      best_metric,
    output logic                  best_valid,
    output logic                  busy
`ifdef CAND_METRIC_INDEX_EN
    ,
    output logic [15:0]           best_index,
    output logic [15:0]           frame_cnt
`endif
);

    logic [J*AWIDTH-1:0] r_row1, r_row2, r_run_row, r_fin_row, w_run_row;
    logic                r_v1, r_l1, r_v2, r_l2, r_ill2, r_first, r_fin_v;
    logic [MET_W-1:0]    r_met2, r_run_met, r_fin_met, w_run_met, w_sum;
    logic [J*COST_W-1:0] w_cost1;
    logic                w_ill1, w_upd, w_none;

    cand_cost_lut #(.J(J), .A(A), .COST_W(COST_W)) u_lut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (cost_wr_en),
        .i_wr_j    (cost_wr_j),
        .i_wr_a    (cost_wr_a),
        .i_wr_data (cost_wr_data),
        .i_frozen  (busy | candidate_row_tvalid),
        .o_wr_err  (cost_wr_err),
        .i_row     (candidate_row),
        .o_cost    (w_cost1),
        .o_illegal (w_ill1)
    );

    // sum of the per-position costs; MET_W leaves headroom for J full-scale terms
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < J; j++)
            w_sum = w_sum + MET_W'(w_cost1[j*COST_W +: COST_W]);
    end

    assign w_upd = r_v2 && !r_ill2 && (r_first || (r_met2 < r_run_met));
    assign w_none = r_first && !w_upd;
    assign w_run_row = w_upd ? r_row2 : r_run_row;
    assign w_run_met = w_upd ? r_met2 : r_run_met;

    // S1 row/tag register and S2 metric register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row1 <= '0;
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
            r_row2 <= '0;
            r_met2 <= '0;
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
            r_ill2 <= 1'b0;
        end else begin
            r_row1 <= candidate_row;
            r_v1 <= candidate_row_tvalid;
            r_l1 <= candidate_row_tvalid && candidate_row_tlast;
            r_row2 <= r_row1;
            r_met2 <= w_sum;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            r_ill2 <= w_ill1;
        end
    end

    // S3 running-best update; the closing beat latches the frame result and re-arms the first-beat flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b1;
            r_run_row <= '0;
            r_run_met <= '0;
            r_fin_v <= 1'b0;
            r_fin_row <= '0;
            r_fin_met <= '0;
        end else begin
            r_fin_v <= r_v2 && r_l2;
            if (r_v2) begin
                r_first <= r_l2 || w_none;
                r_run_row <= w_run_row;
                r_run_met <= w_run_met;
            end
            if (r_v2 && r_l2) begin
                r_fin_row <= w_none ? '0 : w_run_row;
                r_fin_met <= w_none ? MET_MAX[MET_W-1:0] : w_run_met;
            end
        end
    end

    // output stage; busy drops with best_valid unless a newer frame already has beats in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_row <= '0;
            best_metric <= '0;
            best_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            best_valid <= r_fin_v;
            if (r_fin_v) begin
                best_row <= r_fin_row;
                best_metric <= r_fin_met;
            end
            busy <= candidate_row_tvalid ? 1'b1 : (r_fin_v && !r_v1 && !r_v2) ? 1'b0 : busy;
        end
    end

`ifdef CAND_METRIC_INDEX_EN
    logic [15:0] r_cnt, r_run_idx, r_fin_idx;

    // beat position of the winner within its frame and completed-frame count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_run_idx <= '0;
            r_fin_idx <= '0;
            best_index <= '0;
            frame_cnt <= '0;
        end else begin
            if (r_v2) begin
                r_cnt <= r_l2 ? '0 : r_cnt + 16'd1;
                if (w_upd)
                    r_run_idx <= r_cnt;
            end
            if (r_v2 && r_l2)
                r_fin_idx <= w_none ? '0 : (w_upd ? r_cnt : r_run_idx);
            if (r_fin_v) begin
                best_index <= r_fin_idx;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_candidate_metric_select.sv
// tb_candidate_metric_select: directed checks of candidate_metric_select with J=4, A=2, COST_W=8
module tb_candidate_metric_select;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cost_wr_en = 1'b0;
    logic [2:0]  cost_wr_j = '0;
    logic [1:0]  cost_wr_a = '0;
    logic [7:0]  cost_wr_data = '0;
    logic        cost_wr_err;
    logic [7:0]  candidate_row = '0;
    logic        candidate_row_tvalid = 1'b0;
    logic        candidate_row_tlast = 1'b0;
    logic [7:0]  best_row;
    logic [10:0] best_metric;
    logic        best_valid;
    logic        busy;
`ifdef CAND_METRIC_INDEX_EN
    logic [15:0] best_index;
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    candidate_metric_select #(.J(4), .A(2), .COST_W(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cost_wr_en           (cost_wr_en),
        .cost_wr_j            (cost_wr_j),
        .cost_wr_a            (cost_wr_a),
        .cost_wr_data         (cost_wr_data),
        .cost_wr_err          (cost_wr_err),
        .candidate_row        (candidate_row),
        .candidate_row_tvalid (candidate_row_tvalid),
        .candidate_row_tlast  (candidate_row_tlast),
        .best_row             (best_row),
        .best_metric          (best_metric),
        .best_valid           (best_valid),
        .busy                 (busy)
`ifdef CAND_METRIC_INDEX_EN
        ,
        .best_index           (best_index),
        .frame_cnt            (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [7:0] mk(input int x3, input int x2, input int x1, input int x0);
        return {2'(x3), 2'(x2), 2'(x1), 2'(x0)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int j, input int a, input int d);
        cost_wr_en = 1'b1;
        cost_wr_j = 3'(j);
        cost_wr_a = 2'(a);
        cost_wr_data = 8'(d);
        tick;
        cost_wr_en = 1'b0;
    endtask

    task automatic beat(input logic [7:0] row, input logic last);
        candidate_row = row;
        candidate_row_tvalid = 1'b1;
        candidate_row_tlast = last;
        tick;
        candidate_row_tvalid = 1'b0;
        candidate_row_tlast = 1'b0;
    endtask

    task automatic wait_best(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (best_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic load_costs;
        for (int j = 0; j < 4; j++)
            wr(j, 1, j + 1);
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", best_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (best_row !== 8'h00) begin errors++; $display("FAIL reset_row got %0h want 0", best_row); end
        checks++; if (best_metric !== 11'h000) begin errors++; $display("FAIL reset_metric got %0h want 0", best_metric); end
        checks++; if (cost_wr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", cost_wr_err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_cost_write;
        for (int j = 0; j < 4; j++) begin
            wr(j, 1, j + 1);
            checks++; if (cost_wr_err !== 1'b0) begin errors++; $display("FAIL wr_legal_%0d got err %0b want 0", j, cost_wr_err); end
        end
        wr(4, 1, 0);
        checks++; if (cost_wr_err !== 1'b1) begin errors++; $display("FAIL wr_bad_j got err %0b want 1", cost_wr_err); end
        wr(0, 2, 0);
        checks++; if (cost_wr_err !== 1'b1) begin errors++; $display("FAIL wr_bad_a got err %0b want 1", cost_wr_err); end
        tick;
        checks++; if (cost_wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse got %0b want 0", cost_wr_err); end
    endtask

    task automatic test_min_select;
        int lat;
        beat(mk(0,0,0,0), 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL min_busy got %0b want 1", busy); end
        beat(mk(0,0,1,1), 1'b0);
        beat(mk(0,1,0,1), 1'b0);
        beat(mk(1,0,0,0), 1'b1);
        wait_best(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL min_latency got %0d want 3", lat); end
        checks++; if (best_row !== mk(0,0,0,0)) begin errors++; $display("FAIL min_row got %0h want 0", best_row); end
        checks++; if (best_metric !== 11'd0) begin errors++; $display("FAIL min_metric got %0d want 0", best_metric); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL min_busy_clear got %0b want 0", busy); end
`ifdef CAND_METRIC_INDEX_EN
        checks++; if (best_index !== 16'd0) begin errors++; $display("FAIL min_index got %0d want 0", best_index); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL min_frame_cnt got %0d want 1", frame_cnt); end
`endif
        tick;
        checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL min_pulse got %0b want 0", best_valid); end
        checks++; if (best_metric !== 11'd0) begin errors++; $display("FAIL min_hold got %0d want 0", best_metric); end
    endtask

    task automatic test_tie;
        int lat;
        wr(0, 1, 3);
        beat(mk(0,1,0,0), 1'b0);
        beat(mk(0,0,0,1), 1'b1);
        wait_best(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL tie_latency got %0d want 3", lat); end
        checks++; if (best_row !== mk(0,1,0,0)) begin errors++; $display("FAIL tie_row got %0h want %0h", best_row, mk(0,1,0,0)); end
        checks++; if (best_metric !== 11'd3) begin errors++; $display("FAIL tie_metric got %0d want 3", best_metric); end
        wr(0, 1, 1);
    endtask

    task automatic test_illegal;
        int lat;
        beat(mk(0,0,2,0), 1'b0);
        beat(mk(1,1,1,1), 1'b1);
        wait_best(lat);
        checks++; if (best_row !== mk(1,1,1,1)) begin errors++; $display("FAIL ill_row got %0h want 55", best_row); end
        checks++; if (best_metric !== 11'd10) begin errors++; $display("FAIL ill_metric got %0d want 10", best_metric); end
        beat(mk(0,0,2,0), 1'b1);
        wait_best(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL empty_latency got %0d want 3", lat); end
        checks++; if (best_row !== 8'h00) begin errors++; $display("FAIL empty_row got %0h want 0", best_row); end
        checks++; if (best_metric !== 11'h7FF) begin errors++; $display("FAIL empty_metric got %0h want 7ff", best_metric); end
    endtask

    task automatic test_back_to_back;
        int lat;
        beat(mk(0,0,1,1), 1'b1);
        beat(mk(0,0,0,1), 1'b1);
        wait_best(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
        checks++; if (best_metric !== 11'd3) begin errors++; $display("FAIL b2b_first_metric got %0d want 3", best_metric); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_hold got %0b want 1", busy); end
        tick;
        checks++; if (best_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %0b want 1", best_valid); end
        checks++; if (best_metric !== 11'd1) begin errors++; $display("FAIL b2b_second_metric got %0d want 1", best_metric); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clear got %0b want 0", busy); end
    endtask

    task automatic test_midframe_write;
        int lat;
        cost_wr_en = 1'b1;
        cost_wr_j = 3'd1;
        cost_wr_a = 2'd1;
        cost_wr_data = 8'd0;
        beat(mk(0,0,0,1), 1'b0);
        cost_wr_en = 1'b0;
        checks++; if (cost_wr_err !== 1'b1) begin errors++; $display("FAIL first_beat_wr_err got %0b want 1", cost_wr_err); end
        wr(1, 1, 0);
        checks++; if (cost_wr_err !== 1'b1) begin errors++; $display("FAIL midframe_wr_err got %0b want 1", cost_wr_err); end
        beat(mk(0,0,1,0), 1'b1);
        wait_best(lat);
        checks++; if (best_row !== mk(0,0,0,1)) begin errors++; $display("FAIL midframe_row got %0h want 1", best_row); end
        checks++; if (best_metric !== 11'd1) begin errors++; $display("FAIL midframe_metric got %0d want 1", best_metric); end
    endtask

    task automatic test_reset_midframe;
        int lat;
        int seen;
        beat(mk(0,0,1,1), 1'b0);
        beat(mk(0,1,0,1), 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (best_row !== 8'h00) begin errors++; $display("FAIL rst_row got %0h want 0", best_row); end
        checks++; if (best_metric !== 11'd0) begin errors++; $display("FAIL rst_metric got %0d want 0", best_metric); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
        tick;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (best_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_valid got %0d pulses want 0", seen); end
        load_costs();
        beat(mk(1,0,0,0), 1'b1);
        wait_best(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL post_rst_latency got %0d want 3", lat); end
        checks++; if (best_metric !== 11'd4) begin errors++; $display("FAIL post_rst_metric got %0d want 4", best_metric); end
        checks++; if (best_row !== mk(1,0,0,0)) begin errors++; $display("FAIL post_rst_row got %0h want 40", best_row); end
    endtask

    initial begin
        test_reset();
        test_cost_write();
        test_min_select();
        test_tie();
        test_illegal();
        test_back_to_back();
        test_midframe_write();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
